// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Command controller sitting between UART_RX and the PID/PWM datapath.
// Parses fixed 8-byte host frames  AA CMD P4 P3 P2 P1 P0 BB,  loads the
// KP/KI/KD gains or the PID reset flag, and answers every complete frame
// with a single ACK (ACK_BASE|CMD) or NAK byte through the UART_TX handshake.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_n        synchronous reset, active low
//   i_RX_DV        one-cycle strobe, i_RX_Byte valid
//   i_RX_Byte      received byte
//   i_TX_Active    UART_TX busy
//   i_TX_Done      one-cycle strobe, TX byte finished
//   o_TX_DV        one-cycle TX start strobe
//   o_TX_Byte      reply byte, stable from o_TX_DV until i_TX_Done
//   o_KP/o_KI/o_KD gain registers (payload = {P4[3:0],P3,P2,P1,P0})
//   o_PID_Reset    PID reset request level (set after reset)
//   o_Cfg_Update   one-cycle pulse after a register load
//   o_Err_Count    saturating framing/timeout error counter
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int         TIMEOUT_CLKS = 17360,
    parameter int         GAIN_W       = 36,
    parameter logic [7:0] ACK_BASE     = 8'h80,
    parameter logic [7:0] NAK_BYTE     = 8'h15
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    output logic [GAIN_W-1:0] o_KP,
    output logic [GAIN_W-1:0] o_KI,
    output logic [GAIN_W-1:0] o_KD,
    output logic              o_PID_Reset,
    output logic              o_Cfg_Update,
    output logic [7:0]        o_Err_Count
);

    localparam logic [7:0] SOF_BYTE = 8'hAA;
    localparam logic [7:0] EOF_BYTE = 8'hBB;

    // Counter only needs to reach TIMEOUT_CLKS-1.
    localparam int               TMO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_TAIL,
        S_APPLY,
        S_ACK_REQ,
        S_ACK_WAIT
    } state_t;

    state_t             state,    state_nx;
    logic [7:0]         cmd_r,    cmd_nx;
    logic [39:0]        pay_sh,   pay_nx;
    logic [2:0]         idx,      idx_nx;
    logic [TMO_W-1:0]   tmo_cnt,  tmo_nx;
    logic [7:0]         reply_r,  reply_nx;
    logic [GAIN_W-1:0]  kp_r,     kp_nx;
    logic [GAIN_W-1:0]  ki_r,     ki_nx;
    logic [GAIN_W-1:0]  kd_r,     kd_nx;
    logic               pid_rst,  pid_rst_nx;
    logic               cfg_upd,  cfg_upd_nx;
    logic               tx_dv,    tx_dv_nx;
    logic [7:0]         tx_byte,  tx_byte_nx;
    logic [7:0]         err_cnt,  err_cnt_nx;

    logic               in_frame;
    logic [7:0]         err_inc;
    logic [GAIN_W-1:0]  payload;

    // Frame collection states are the only ones guarded by the timeout.
    assign in_frame = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_TAIL);
    assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    // P4[7:4] falls off the top here.
    assign payload  = pay_sh[GAIN_W-1:0];

    always_comb begin
        state_nx   = state;
        cmd_nx     = cmd_r;
        pay_nx     = pay_sh;
        idx_nx     = idx;
        tmo_nx     = tmo_cnt;
        reply_nx   = reply_r;
        kp_nx      = kp_r;
        ki_nx      = ki_r;
        kd_nx      = kd_r;
        pid_rst_nx = pid_rst;
        cfg_upd_nx = 1'b0;
        tx_dv_nx   = 1'b0;
        tx_byte_nx = tx_byte;
        err_cnt_nx = err_cnt;

        // Inter-byte timeout. A byte arriving on the expiry cycle wins, so
        // expiry is only taken when no DV is present; the DV cases below
        // then own the state transition.
        if (in_frame) begin
            if (i_RX_DV) begin
                tmo_nx = '0;
            end else if (tmo_cnt == TMO_LAST) begin
                state_nx   = S_IDLE;
                tmo_nx     = '0;
                err_cnt_nx = err_inc;
            end else begin
                tmo_nx = tmo_cnt + TMO_W'(1);
            end
        end

        unique case (state)
            S_IDLE: begin
                // Anything but a start byte is line noise.
                if (i_RX_DV && (i_RX_Byte == SOF_BYTE)) begin
                    state_nx = S_CMD;
                    tmo_nx   = '0;
                end
            end

            S_CMD: begin
                if (i_RX_DV) begin
                    cmd_nx   = i_RX_Byte;
                    idx_nx   = 3'd0;
                    state_nx = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                if (i_RX_DV) begin
                    pay_nx = {pay_sh[31:0], i_RX_Byte};
                    idx_nx = idx + 3'd1;
                    if (idx == 3'd4) begin
                        state_nx = S_TAIL;
                    end
                end
            end

            S_TAIL: begin
                if (i_RX_DV) begin
                    if ((i_RX_Byte == EOF_BYTE) && (cmd_r <= 8'd4)) begin
                        state_nx = S_APPLY;
                    end else begin
                        reply_nx   = NAK_BYTE;
                        err_cnt_nx = err_inc;
                        state_nx   = S_ACK_REQ;
                    end
                end
            end

            S_APPLY: begin
                unique case (cmd_r)
                    8'd0:    pid_rst_nx = 1'b1;
                    8'd1:    kp_nx      = payload;
                    8'd2:    kd_nx      = payload;
                    8'd3:    ki_nx      = payload;
                    8'd4:    pid_rst_nx = 1'b0;
                    default: ;
                endcase
                cfg_upd_nx = 1'b1;
                reply_nx   = ACK_BASE | cmd_r;
                state_nx   = S_ACK_REQ;
            end

            S_ACK_REQ: begin
                if (!i_TX_Active) begin
                    tx_dv_nx   = 1'b1;
                    tx_byte_nx = reply_r;
                    state_nx   = S_ACK_WAIT;
                end
            end

            S_ACK_WAIT: begin
                if (i_TX_Done) begin
                    state_nx = S_IDLE;
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            cmd_r   <= '0;
            pay_sh  <= '0;
            idx     <= '0;
            tmo_cnt <= '0;
            reply_r <= '0;
            kp_r    <= '0;
            ki_r    <= '0;
            kd_r    <= '0;
            pid_rst <= 1'b1;   // PID held until the host releases it
            cfg_upd <= 1'b0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_nx;
            cmd_r   <= cmd_nx;
            pay_sh  <= pay_nx;
            idx     <= idx_nx;
            tmo_cnt <= tmo_nx;
            reply_r <= reply_nx;
            kp_r    <= kp_nx;
            ki_r    <= ki_nx;
            kd_r    <= kd_nx;
            pid_rst <= pid_rst_nx;
            cfg_upd <= cfg_upd_nx;
            tx_dv   <= tx_dv_nx;
            tx_byte <= tx_byte_nx;
            err_cnt <= err_cnt_nx;
        end
    end

    assign o_TX_DV      = tx_dv;
    assign o_TX_Byte    = tx_byte;
    assign o_KP         = kp_r;
    assign o_KI         = ki_r;
    assign o_KD         = kd_r;
    assign o_PID_Reset  = pid_rst;
    assign o_Cfg_Update = cfg_upd;
    assign o_Err_Count  = err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Self-checking bench: directed frames from the test plan plus random frames,
// checked against a frame-level reference model (gain/flag/error variables
// updated per whole frame). A small UART_TX stand-in answers o_TX_DV with a
// busy window and a done strobe.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        busy_emu = 1'b0;
    logic        hold_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_active;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [35:0] kp, ki, kd;
    logic        pid_reset;
    logic        cfg_update;
    logic [7:0]  err_count;

    assign tx_active = busy_emu | hold_busy;

    uart_cmd_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_RX_DV      (rx_dv),
        .i_RX_Byte    (rx_byte),
        .i_TX_Active  (tx_active),
        .i_TX_Done    (tx_done),
        .o_TX_DV      (tx_dv),
        .o_TX_Byte    (tx_byte),
        .o_KP         (kp),
        .o_KI         (ki),
        .o_KD         (kd),
        .o_PID_Reset  (pid_reset),
        .o_Cfg_Update (cfg_update),
        .o_Err_Count  (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cfg_cnt = 0;
    int dv_cnt = 0;
    logic [7:0] tx_q[$];

    // Frame-level reference state
    logic [35:0] m_kp, m_ki, m_kd;
    logic        m_pid;
    int          m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_kp = '0; m_ki = '0; m_kd = '0; m_pid = 1'b1; m_err = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    // Whole-frame rule: good tail + known command -> load + ACK, else NAK + error.
    task automatic model_frame(input logic [7:0] c, input logic [39:0] pl, input logic [7:0] tl,
                               output logic [7:0] exp_r, output int exp_cfg);
        if (tl == 8'hBB && c <= 8'd4) begin
            exp_cfg = 1;
            exp_r   = 8'h80 | c;
            case (c)
                8'd0: m_pid = 1'b1;
                8'd1: m_kp  = pl[35:0];
                8'd2: m_kd  = pl[35:0];
                8'd3: m_ki  = pl[35:0];
                8'd4: m_pid = 1'b0;
                default: ;
            endcase
        end else begin
            exp_cfg = 0;
            exp_r   = 8'h15;
            model_err();
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_kp"},  64'(kp),        64'(m_kp));
        chk({tag, "_ki"},  64'(ki),        64'(m_ki));
        chk({tag, "_kd"},  64'(kd),        64'(m_kd));
        chk({tag, "_pid"}, 64'(pid_reset), 64'(m_pid));
        chk({tag, "_err"}, 64'(err_count), 64'(m_err));
    endtask

    // Callers sit at posedge+1; DV is sampled gap+1 edges later.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [39:0] pl, input logic [7:0] tl,
                              input int gmax, input int tail_gap);
        logic [7:0] fr[8];
        int g;
        fr = '{8'hAA, c, pl[39:32], pl[31:24], pl[23:16], pl[15:8], pl[7:0], tl};
        for (int i = 0; i < 8; i++) begin
            g = int'($urandom_range(0, gmax));
            if (i == 7 && tail_gap >= 0) g = tail_gap;
            send_byte(fr[i], g);
        end
    endtask

    task automatic wait_idle();
        int n;
        repeat (2) @(posedge clk);
        n = 0;
        while (busy_emu && n < 200) begin
            @(posedge clk); n++;
        end
        if (busy_emu) chk("idle_bound", 64'd1, 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [39:0] pl, input logic [7:0] tl,
                             input int gmax, input int tail_gap);
        logic [7:0] exp_r;
        int exp_cfg, c0, d0;
        bit got;
        wait_idle();
        tx_q.delete();
        c0 = cfg_cnt; d0 = dv_cnt;
        model_frame(c, pl, tl, exp_r, exp_cfg);
        send_frame(c, pl, tl, gmax, tail_gap);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (tx_q.size() > 0) got = 1'b1;
        end
        chk($sformatf("reply_seen c%0h", c), 64'(got), 64'd1);
        if (got) chk($sformatf("reply c%0h", c), 64'(tx_q.pop_front()), 64'(exp_r));
        wait_idle();
        check_regs($sformatf("frame c%0h", c));
        chk($sformatf("cfg_pulses c%0h", c), 64'(cfg_cnt - c0), 64'(exp_cfg));
        chk($sformatf("tx_dv_pulses c%0h", c), 64'(dv_cnt - d0), 64'd1);
    endtask

    always @(negedge clk) begin
        if (cfg_update) cfg_cnt <= cfg_cnt + 1;
        if (tx_dv)      dv_cnt  <= dv_cnt + 1;
    end

    // UART_TX stand-in
    logic [7:0] emu_b;
    int         emu_n;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                emu_b = tx_byte;
                tx_q.push_back(emu_b);
                @(posedge clk); #1 busy_emu = 1'b1;
                emu_n = int'($urandom_range(4, 10));
                repeat (emu_n) @(posedge clk);
                #1;
                chk("tx_byte_hold", 64'(tx_byte), 64'(emu_b));
                tx_done = 1'b1; busy_emu = 1'b0;
                @(posedge clk); #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  c, tl, exp_r;
        logic [39:0] pl;
        int d0, exp_cfg;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_regs("rst");
        chk("rst_cfg",     64'(cfg_update), 64'd0);
        chk("rst_tx_dv",   64'(tx_dv),      64'd0);
        chk("rst_tx_byte", 64'(tx_byte),    64'd0);
        @(posedge clk); #1;

        // Directed frames
        run_frame(8'h01, 40'h0512345678, 8'hBB, 2, -1);
        run_frame(8'h02, 40'hF300000001, 8'hBB, 2, -1);
        run_frame(8'h03, 40'h0ABCDE0123, 8'hBB, 2, -1);
        run_frame(8'h04, 40'h0000000000, 8'hBB, 2, -1);
        run_frame(8'h00, 40'h0000000000, 8'hBB, 2, -1);
        run_frame(8'h07, 40'h0000000000, 8'hBB, 2, -1);
        run_frame(8'h03, 40'h0000000009, 8'hCC, 2, -1);

        // Leading noise, then a good frame
        wait_idle();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        run_frame(8'h01, 40'h0111111111, 8'hBB, 1, -1);

        // Timeout mid-frame: error, no reply, then normal operation
        wait_idle();
        d0 = dv_cnt;
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        repeat (TMO + 20) @(posedge clk);
        #1;
        model_err();
        check_regs("tmo");
        chk("tmo_no_tx", 64'(dv_cnt - d0), 64'd0);
        run_frame(8'h02, 40'h0022222222, 8'hBB, 1, -1);

        // Tail arriving exactly on the expiry cycle is accepted
        run_frame(8'h03, 40'h0333333333, 8'hBB, 0, TMO - 1);

        // Random frames
        for (int i = 0; i < 60; i++) begin
            c  = ($urandom_range(0, 9) == 9) ? 8'($urandom) : 8'($urandom_range(0, 6));
            tl = 8'hBB;
            if ($urandom_range(0, 4) == 0) begin
                tl = 8'($urandom);
                if (tl == 8'hBB) tl = 8'hCC;
            end
            pl = {8'($urandom), 32'($urandom)};
            run_frame(c, pl, tl, 3, -1);
        end

        // TX backpressure, then bytes during ACK_WAIT are dropped
        wait_idle();
        tx_q.delete();
        d0 = dv_cnt;
        hold_busy = 1'b1;
        pl = {8'($urandom), 32'($urandom)};
        model_frame(8'h01, pl, 8'hBB, exp_r, exp_cfg);
        send_frame(8'h01, pl, 8'hBB, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_held_dv", 64'(dv_cnt - d0), 64'd0);
        chk("bp_kp", 64'(kp), 64'(m_kp));
        hold_busy = 1'b0;
        @(negedge clk);
        chk("bp_dv_early", 64'(tx_dv), 64'd0);
        @(negedge clk);
        chk("bp_dv", 64'(tx_dv), 64'd1);
        chk("bp_byte", 64'(tx_byte), 64'(exp_r));
        @(posedge clk); #1;
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        wait_idle();
        chk("bp_dv_total", 64'(dv_cnt - d0), 64'd1);
        run_frame(8'h03, 40'h0444444444, 8'hBB, 1, -1);

        // Reset mid-payload
        wait_idle();
        d0 = dv_cnt;
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        send_byte(8'h12, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_regs("midrst");
        chk("midrst_tx_byte", 64'(tx_byte), 64'd0);
        chk("midrst_tx_dv",   64'(tx_dv),   64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_tx", 64'(dv_cnt - d0), 64'd0);
        run_frame(8'h01, 40'h0512345678, 8'hBB, 1, -1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            run_frame(8'h01, 40'h0000000000, 8'h00, 0, -1);
        end
        chk("err_sat", 64'(err_count), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
